// File: rtl/system_flit_decoder.sv
// rtl/system_flit_decoder.sv - combinational decoder for SYSTEM-type router flits
//
// Purpose: classifies an incoming flit, exposes its system header/payload and
// raises one-cycle update strobes towards the router state registers. Also
// restarts the router's internal timer on parent acceptance or INIT timeout.
//
// Ports:
//   nocclk, rst_n            clock (unused by the datapath) and async active-low reset
//   flit_in, flit_valid      incoming flit and its qualifier
//   routing_state            current router state (INIT / NORMAL / FATAL_ERROR)
//   this_node_id             current own node id
//   internal_timer           cycles since the last timer_rst
//   timer_rst                restart internal_timer
//   is_system_flit, is_init, is_join_ack_parent   classification flags
//   system_header, system_payload                 decoded system fields
//   update_*_valid / update_*                     state/table update strobes
//   is_raw_global_destination_used_to_update_routing_table
//   next_routing_state, global_destination_id

package types;
  typedef logic [7:0] node_id_t;
  typedef enum logic [1:0] {
    DATA     = 2'd0,
    SYSTEM   = 2'd1,
    CONTROL  = 2'd2,
    RESERVED = 2'd3
  } flit_type_e;
  localparam int FLIT_PAYLOAD_W = 35;
  typedef struct packed {
    flit_type_e flittype;
  } flit_header_t;
  typedef struct packed {
    flit_header_t                header;
    logic [FLIT_PAYLOAD_W-1:0]   payload;
  } flit_t;
endpackage

package system_types;
  typedef enum logic [1:0] {
    INIT        = 2'd0,
    NORMAL      = 2'd1,
    FATAL_ERROR = 2'd2
  } routing_state_t;
  typedef enum logic [2:0] {
    S_NOPE           = 3'd0,
    S_PARENT_REQUEST = 3'd1,
    S_PARENT_ACK     = 3'd2,
    S_JOIN_REQUEST   = 3'd3,
    S_JOIN_ACK       = 3'd4
  } system_msg_e;
  typedef struct packed {
    system_msg_e    msg;
    types::node_id_t src_id;
    types::node_id_t dst_id;
  } system_header_t;
  typedef struct packed {
    logic        is_init;
    logic [14:0] rsvd;
  } parent_request_t;
  typedef struct packed {
    types::node_id_t node_id;
    logic [7:0]      rsvd;
  } node_payload_t;
  typedef union packed {
    parent_request_t parent_request;
    node_payload_t   join_request;
    node_payload_t   join_ack;
  } system_payload_t;
  typedef struct packed {
    system_header_t  header;
    system_payload_t payload;
  } system_flit_t;
endpackage

module system_flit_decoder #(
  parameter int MAX_INTERNAL_TIMER = 1000,
  parameter bit IS_ROOT            = 1'b0
) (
  input  logic                                    nocclk,
  input  logic                                    rst_n,
  input  types::flit_t                            flit_in,
  input  logic                                    flit_valid,
  input  system_types::routing_state_t            routing_state,
  input  types::node_id_t                         this_node_id,
  input  logic [$clog2(MAX_INTERNAL_TIMER):0]     internal_timer,
  output logic                                    timer_rst,
  output logic                                    is_system_flit,
  output logic                                    is_init,
  output logic                                    is_join_ack_parent,
  output system_types::system_header_t            system_header,
  output system_types::system_payload_t           system_payload,
  output logic                                    update_parent_valid,
  output types::node_id_t                         update_parent_node_id,
  output logic                                    update_this_node_valid,
  output types::node_id_t                         update_this_node_id,
  output logic                                    update_neighbor_id_valid,
  output types::node_id_t                         update_neighbor_id,
  output logic                                    update_routing_table_valid,
  output types::node_id_t                         update_routing_table_key,
  output logic                                    is_raw_global_destination_used_to_update_routing_table,
  output logic                                    update_next_state,
  output system_types::routing_state_t            next_routing_state,
  output types::node_id_t                         global_destination_id
);
  import system_types::*;

  localparam int TIMER_W = $clog2(MAX_INTERNAL_TIMER) + 1;
  localparam logic [TIMER_W-1:0] TIMEOUT = TIMER_W'(MAX_INTERNAL_TIMER);

  // The clock only exists for interface symmetry; no state is held here.
  logic unused_clk;
  assign unused_clk = nocclk;

  system_flit_t sys_view;
  logic         sys_hit;

  always_comb begin
    sys_view = flit_in.payload;
    sys_hit  = rst_n && flit_valid && (flit_in.header.flittype == types::SYSTEM);
  end

  always_comb begin
    timer_rst                  = 1'b0;
    is_system_flit             = 1'b0;
    is_init                    = 1'b0;
    is_join_ack_parent         = 1'b0;
    system_header              = '0;
    system_payload             = '0;
    update_parent_valid        = 1'b0;
    update_parent_node_id      = '0;
    update_this_node_valid     = 1'b0;
    update_this_node_id        = '0;
    update_neighbor_id_valid   = 1'b0;
    update_neighbor_id         = '0;
    update_routing_table_valid = 1'b0;
    update_routing_table_key   = '0;
    is_raw_global_destination_used_to_update_routing_table = 1'b0;
    update_next_state          = 1'b0;
    next_routing_state         = FATAL_ERROR;
    global_destination_id      = '0;

    // Parent search timeout runs independently of flit traffic.
    if (rst_n && !IS_ROOT && routing_state == INIT && internal_timer >= TIMEOUT) begin
      timer_rst = 1'b1;
    end

    if (sys_hit) begin
      is_system_flit        = 1'b1;
      system_header         = sys_view.header;
      system_payload        = sys_view.payload;
      global_destination_id = sys_view.header.src_id;

      case (sys_view.header.msg)
        S_PARENT_REQUEST: begin
          // Answered by the controller in NORMAL; nothing to update here.
          is_init = sys_view.payload.parent_request.is_init;
        end
        S_PARENT_ACK: begin
          if (!IS_ROOT && routing_state == INIT && sys_view.header.dst_id == this_node_id) begin
            update_parent_valid      = 1'b1;
            update_parent_node_id    = sys_view.header.src_id;
            update_neighbor_id_valid = 1'b1;
            update_neighbor_id       = sys_view.header.src_id;
            timer_rst                = 1'b1;
            update_next_state        = 1'b1;
            next_routing_state       = NORMAL;
          end
        end
        S_JOIN_REQUEST: begin
          // The joining node is reached through the requester, so the table
          // value is the raw node id rather than the hop source.
          if (routing_state == NORMAL) begin
            update_routing_table_valid = 1'b1;
            update_routing_table_key   = sys_view.payload.join_request.node_id;
            is_raw_global_destination_used_to_update_routing_table = 1'b1;
            global_destination_id      = sys_view.payload.join_request.node_id;
          end
        end
        S_JOIN_ACK: begin
          if (sys_view.header.dst_id == this_node_id) begin
            is_join_ack_parent     = 1'b1;
            update_this_node_valid = 1'b1;
            update_this_node_id    = sys_view.payload.join_ack.node_id;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_system_flit_decoder.sv
// tb/tb_system_flit_decoder.sv - scoreboard bench for system_flit_decoder
module tb_system_flit_decoder;
  import system_types::*;

  typedef struct packed {
    logic            timer_rst;
    logic            is_sys;
    logic            is_init;
    logic            jap;
    logic            upv;
    logic            utv;
    logic            unv;
    logic            urv;
    logic            raw;
    logic            uns;
    types::node_id_t up_id;
    types::node_id_t ut_id;
    types::node_id_t un_id;
    types::node_id_t ur_key;
    types::node_id_t gdst;
    system_header_t  hdr;
    system_payload_t pl;
    routing_state_t  nrs;
    logic            root_timer_rst;
    logic            root_upv;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  types::flit_t    flit_in;
  logic            flit_valid;
  routing_state_t  routing_state;
  types::node_id_t this_node_id;
  logic [10:0]     internal_timer;

  logic            timer_rst, is_system_flit, is_init, is_join_ack_parent;
  system_header_t  system_header;
  system_payload_t system_payload;
  logic            upv, utv, unv, urv, raw_flag, uns;
  types::node_id_t up_id, ut_id, un_id, ur_key, gdst;
  routing_state_t  nrs;

  logic            r_timer_rst, r_is_sys, r_is_init, r_jap;
  system_header_t  r_hdr;
  system_payload_t r_pl;
  logic            r_upv, r_utv, r_unv, r_urv, r_raw, r_uns;
  types::node_id_t r_up_id, r_ut_id, r_un_id, r_ur_key, r_gdst;
  routing_state_t  r_nrs;

  int checks = 0;
  int failures = 0;
  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  system_flit_decoder #(.MAX_INTERNAL_TIMER(1000), .IS_ROOT(1'b0)) dut (
    .nocclk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_valid(flit_valid),
    .routing_state(routing_state), .this_node_id(this_node_id), .internal_timer(internal_timer),
    .timer_rst(timer_rst), .is_system_flit(is_system_flit), .is_init(is_init),
    .is_join_ack_parent(is_join_ack_parent), .system_header(system_header),
    .system_payload(system_payload),
    .update_parent_valid(upv), .update_parent_node_id(up_id),
    .update_this_node_valid(utv), .update_this_node_id(ut_id),
    .update_neighbor_id_valid(unv), .update_neighbor_id(un_id),
    .update_routing_table_valid(urv), .update_routing_table_key(ur_key),
    .is_raw_global_destination_used_to_update_routing_table(raw_flag),
    .update_next_state(uns), .next_routing_state(nrs), .global_destination_id(gdst)
  );

  system_flit_decoder #(.MAX_INTERNAL_TIMER(1000), .IS_ROOT(1'b1)) dut_root (
    .nocclk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_valid(flit_valid),
    .routing_state(routing_state), .this_node_id(this_node_id), .internal_timer(internal_timer),
    .timer_rst(r_timer_rst), .is_system_flit(r_is_sys), .is_init(r_is_init),
    .is_join_ack_parent(r_jap), .system_header(r_hdr), .system_payload(r_pl),
    .update_parent_valid(r_upv), .update_parent_node_id(r_up_id),
    .update_this_node_valid(r_utv), .update_this_node_id(r_ut_id),
    .update_neighbor_id_valid(r_unv), .update_neighbor_id(r_un_id),
    .update_routing_table_valid(r_urv), .update_routing_table_key(r_ur_key),
    .is_raw_global_destination_used_to_update_routing_table(r_raw),
    .update_next_state(r_uns), .next_routing_state(r_nrs), .global_destination_id(r_gdst)
  );

  function automatic types::flit_t mk(input logic [1:0] ft, input logic [2:0] msg,
                                      input logic [7:0] src, input logic [7:0] dst,
                                      input logic [15:0] pl);
    types::flit_t f;
    f.header.flittype = types::flit_type_e'(ft);
    f.payload = {msg, src, dst, pl};
    return f;
  endfunction

  function automatic exp_t dflt();
    exp_t e;
    e = '0;
    e.nrs = FATAL_ERROR;
    return e;
  endfunction

  task automatic apply(input string nm, input logic rn, input types::flit_t f, input logic v,
                       input routing_state_t st, input logic [7:0] me, input logic [10:0] tmr,
                       input exp_t e);
    @(posedge clk);
    rst_n = rn;
    flit_in = f;
    flit_valid = v;
    routing_state = st;
    this_node_id = me;
    internal_timer = tmr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input string grp, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, grp, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "flags",
          64'({timer_rst, is_system_flit, is_init, is_join_ack_parent, upv, utv, unv, urv, raw_flag, uns}),
          64'({e.timer_rst, e.is_sys, e.is_init, e.jap, e.upv, e.utv, e.unv, e.urv, e.raw, e.uns}));
      chk(nm, "ids", 64'({up_id, ut_id, un_id, ur_key, gdst}),
          64'({e.up_id, e.ut_id, e.un_id, e.ur_key, e.gdst}));
      chk(nm, "hdr", 64'({system_header, system_payload, nrs}), 64'({e.hdr, e.pl, e.nrs}));
      chk(nm, "root", 64'({r_timer_rst, r_upv}), 64'({e.root_timer_rst, e.root_upv}));
    end
  end

  initial begin
    exp_t e;
    types::flit_t pack1;
    rst_n = 1'b0;
    flit_in = '0;
    flit_valid = 1'b0;
    routing_state = INIT;
    this_node_id = 8'd1;
    internal_timer = 11'd0;
    pack1 = mk(2'd1, 3'd2, 8'd5, 8'd1, 16'h0000);

    apply("reset_hold", 1'b0, pack1, 1'b1, INIT, 8'd1, 11'd1000, dflt());
    apply("idle", 1'b1, '0, 1'b0, INIT, 8'd1, 11'd100, dflt());

    e = dflt(); e.is_sys = 1; e.is_init = 1; e.hdr = {3'd1, 8'd0, 8'd1}; e.pl = 16'h8000; e.gdst = 8'd0;
    apply("preq_normal", 1'b1, mk(2'd1, 3'd1, 8'd0, 8'd1, 16'h8000), 1'b1, NORMAL, 8'd1, 11'd100, e);
    apply("preq_init", 1'b1, mk(2'd1, 3'd1, 8'd0, 8'd1, 16'h8000), 1'b1, INIT, 8'd1, 11'd100, e);

    e = dflt(); e.is_sys = 1; e.upv = 1; e.up_id = 8'd5; e.unv = 1; e.un_id = 8'd5;
    e.timer_rst = 1; e.uns = 1; e.nrs = NORMAL; e.gdst = 8'd5; e.hdr = {3'd2, 8'd5, 8'd1};
    apply("pack_init", 1'b1, pack1, 1'b1, INIT, 8'd1, 11'd100, e);
    apply("pack_plus_timeout", 1'b1, pack1, 1'b1, INIT, 8'd1, 11'd1000, e);

    e = dflt(); e.is_sys = 1; e.gdst = 8'd5; e.hdr = {3'd2, 8'd5, 8'd2};
    apply("pack_other_dst", 1'b1, mk(2'd1, 3'd2, 8'd5, 8'd2, 16'h0000), 1'b1, INIT, 8'd1, 11'd100, e);
    e = dflt(); e.is_sys = 1; e.gdst = 8'd5; e.hdr = {3'd2, 8'd5, 8'd1};
    apply("pack_normal", 1'b1, pack1, 1'b1, NORMAL, 8'd1, 11'd100, e);

    e = dflt(); e.timer_rst = 1;
    apply("timeout_init", 1'b1, '0, 1'b0, INIT, 8'd1, 11'd1000, e);
    apply("timer_999", 1'b1, '0, 1'b0, INIT, 8'd1, 11'd999, dflt());
    apply("timer_normal", 1'b1, '0, 1'b0, NORMAL, 8'd1, 11'd1000, dflt());

    e = dflt(); e.is_sys = 1; e.urv = 1; e.ur_key = 8'd7; e.raw = 1; e.gdst = 8'd7;
    e.hdr = {3'd3, 8'd3, 8'd1}; e.pl = 16'h0700;
    apply("jreq_normal", 1'b1, mk(2'd1, 3'd3, 8'd3, 8'd1, 16'h0700), 1'b1, NORMAL, 8'd1, 11'd100, e);
    e = dflt(); e.is_sys = 1; e.gdst = 8'd3; e.hdr = {3'd3, 8'd3, 8'd1}; e.pl = 16'h0700;
    apply("jreq_init", 1'b1, mk(2'd1, 3'd3, 8'd3, 8'd1, 16'h0700), 1'b1, INIT, 8'd1, 11'd100, e);

    e = dflt(); e.is_sys = 1; e.jap = 1; e.utv = 1; e.ut_id = 8'd9; e.gdst = 8'd4;
    e.hdr = {3'd4, 8'd4, 8'd1}; e.pl = 16'h0900;
    apply("jack_me", 1'b1, mk(2'd1, 3'd4, 8'd4, 8'd1, 16'h0900), 1'b1, NORMAL, 8'd1, 11'd100, e);
    e = dflt(); e.is_sys = 1; e.gdst = 8'd4; e.hdr = {3'd4, 8'd4, 8'd2}; e.pl = 16'h0900;
    apply("jack_other", 1'b1, mk(2'd1, 3'd4, 8'd4, 8'd2, 16'h0900), 1'b1, NORMAL, 8'd1, 11'd100, e);

    e = dflt(); e.is_sys = 1; e.gdst = 8'd2; e.hdr = {3'd6, 8'd2, 8'd1}; e.pl = 16'h1234;
    apply("unknown_hdr", 1'b1, mk(2'd1, 3'd6, 8'd2, 8'd1, 16'h1234), 1'b1, NORMAL, 8'd1, 11'd100, e);

    apply("non_system", 1'b1, mk(2'd0, 3'd2, 8'd5, 8'd1, 16'h0000), 1'b1, INIT, 8'd1, 11'd100, dflt());
    apply("not_valid", 1'b1, pack1, 1'b0, INIT, 8'd1, 11'd100, dflt());

    e = dflt(); e.is_sys = 1; e.upv = 1; e.up_id = 8'd9; e.unv = 1; e.un_id = 8'd9;
    e.timer_rst = 1; e.uns = 1; e.nrs = NORMAL; e.gdst = 8'd9; e.hdr = {3'd2, 8'd9, 8'd5};
    apply("pack_id5", 1'b1, mk(2'd1, 3'd2, 8'd9, 8'd5, 16'h0000), 1'b1, INIT, 8'd5, 11'd100, e);

    apply("reset_mid_flit", 1'b0, pack1, 1'b1, INIT, 8'd1, 11'd100, dflt());

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
